// File: rtl/dff_cond_pkg.sv
// Shared types and constants for the dff_input_conditioner debounce stage.
// The optional edge-strobe feature is controlled by DFF_COND_EDGE_EN.
package dff_cond_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        FILTER = 1'b1
    } cond_state_t;

    localparam int DFF_COND_DEBOUNCE_DEFAULT = 4;

    // Counter must hold DEBOUNCE_CYCLES itself, hence the +1.
    function automatic int cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/dff_input_conditioner_if.sv
// Channel bundle between the pad side and the flip-flop core.
// Level-only bus: no valid/ready; every member is a sampled level or a one-cycle strobe.
interface dff_input_conditioner_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] clean_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic [WIDTH-1:0] filtering;

    modport master (
        output raw_in,
        input  clean_out,
        input  rise_pulse,
        input  fall_pulse,
        input  filtering
    );

    modport slave (
        input  raw_in,
        output clean_out,
        output rise_pulse,
        output fall_pulse,
        output filtering
    );
endinterface

// File: rtl/dff_cond_channel.sv
// One channel: 2-flop synchronizer, STABLE/FILTER debounce FSM and optional
// edge strobes (built only when DFF_COND_EDGE_EN is defined).
module dff_cond_channel
    import dff_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DFF_COND_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o,
    output logic filtering_o
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          s1_q;
    logic          s2_q;
    logic          clean_q;
    logic          filtering_q;
    cond_state_t   state_q;
    logic [CW-1:0] cnt_q;
    logic          accept;

    // A change is accepted on the edge that sees the D+1-th differing sample.
    assign accept = (state_q == FILTER) && (s2_q != clean_q) && (cnt_q == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= STABLE;
            cnt_q       <= '0;
            clean_q     <= 1'b0;
            filtering_q <= 1'b0;
        end else begin
            case (state_q)
                STABLE: begin
                    if (s2_q != clean_q) begin
                        state_q     <= FILTER;
                        cnt_q       <= CNT_ONE;
                        filtering_q <= 1'b1;
                    end
                end
                FILTER: begin
                    if (s2_q == clean_q) begin
                        state_q     <= STABLE;
                        cnt_q       <= '0;
                        filtering_q <= 1'b0;
                    end else if (accept) begin
                        clean_q     <= ~clean_q;
                        state_q     <= STABLE;
                        cnt_q       <= '0;
                        filtering_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q     <= STABLE;
                    cnt_q       <= '0;
                    filtering_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef DFF_COND_EDGE_EN
    logic rise_q;
    logic fall_q;

    // Strobes share the edge that flips clean_q; clean_q still holds the old level here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= accept & ~clean_q;
            fall_q <= accept & clean_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

    assign clean_o     = clean_q;
    assign filtering_o = filtering_q;

endmodule

// File: rtl/dff_input_conditioner.sv
// Top: WIDTH independent debounce channels feeding the D flip-flop core.
// Edge strobes exist only when DFF_COND_EDGE_EN is defined; otherwise tied to 0.
module dff_input_conditioner
    import dff_cond_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = DFF_COND_DEBOUNCE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    dff_input_conditioner_if.slave   bus
);

    logic [WIDTH-1:0] clean_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] filtering_w;

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        dff_cond_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .raw_i       (bus.raw_in[g]),
            .clean_o     (clean_w[g]),
            .rise_o      (rise_w[g]),
            .fall_o      (fall_w[g]),
            .filtering_o (filtering_w[g])
        );
    end

    assign bus.clean_out  = clean_w;
    assign bus.rise_pulse = rise_w;
    assign bus.fall_pulse = fall_w;
    assign bus.filtering  = filtering_w;

endmodule

// File: tb/tb_dff_input_conditioner.sv
// Bench for dff_input_conditioner: DUT A (DEBOUNCE_CYCLES=4) and DUT B (=1),
// directed scenarios plus random stimulus against a sliding-window reference model.
module tb_dff_input_conditioner;
    import dff_cond_pkg::*;

    localparam int W  = 2;
    localparam int DA = 4;
    localparam int DB = 1;
`ifdef DFF_COND_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    dff_input_conditioner_if #(.WIDTH(W)) bus_a ();
    dff_input_conditioner_if #(.WIDTH(W)) bus_b ();

    dff_input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(DA)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    dff_input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model channels 0..1 belong to DUT A, 2..3 to DUT B.
    logic [1:0]  m_pipe  [4];
    logic [31:0] m_seen  [4];
    logic        m_clean [4];
    logic        m_rise  [4];
    logic        m_fall  [4];
    logic        m_filt  [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset(input int m);
        m_pipe[m]  = '0;
        m_seen[m]  = '0;
        m_clean[m] = 1'b0;
        m_rise[m]  = 1'b0;
        m_fall[m]  = 1'b0;
        m_filt[m]  = 1'b0;
    endfunction

    // The filter sees raw delayed by two edges; a level is accepted once the last
    // d+1 seen samples all differ from the current clean level.
    function automatic void model_step(input int m, input int d, input logic r);
        logic seen_now;
        logic all_diff;
        seen_now  = m_pipe[m][1];
        m_pipe[m] = {m_pipe[m][0], r};
        m_seen[m] = {m_seen[m][30:0], seen_now};
        all_diff  = 1'b1;
        for (int i = 0; i <= d; i++)
            if (m_seen[m][i] == m_clean[m]) all_diff = 1'b0;
        m_rise[m] = 1'b0;
        m_fall[m] = 1'b0;
        if (all_diff) begin
            m_clean[m] = ~m_clean[m];
            m_rise[m]  = EDGE_EN && m_clean[m];
            m_fall[m]  = EDGE_EN && !m_clean[m];
            m_filt[m]  = 1'b0;
        end else begin
            m_filt[m] = (seen_now != m_clean[m]);
        end
    endfunction

    task automatic check_all();
        for (int c = 0; c < W; c++) begin
            chk($sformatf("a_clean[%0d]", c), bus_a.clean_out[c],  m_clean[c]);
            chk($sformatf("a_rise[%0d]", c),  bus_a.rise_pulse[c], m_rise[c]);
            chk($sformatf("a_fall[%0d]", c),  bus_a.fall_pulse[c], m_fall[c]);
            chk($sformatf("a_filt[%0d]", c),  bus_a.filtering[c],  m_filt[c]);
            chk($sformatf("b_clean[%0d]", c), bus_b.clean_out[c],  m_clean[c+2]);
            chk($sformatf("b_rise[%0d]", c),  bus_b.rise_pulse[c], m_rise[c+2]);
            chk($sformatf("b_fall[%0d]", c),  bus_b.fall_pulse[c], m_fall[c+2]);
            chk($sformatf("b_filt[%0d]", c),  bus_b.filtering[c],  m_filt[c+2]);
        end
    endtask

    // Advance past one rising edge, update the model from the inputs it sampled, compare.
    task automatic cycle();
        @(negedge clk);
        for (int c = 0; c < W; c++) begin
            if (rst_a) model_reset(c);
            else       model_step(c, DA, bus_a.raw_in[c]);
            if (rst_b) model_reset(c + 2);
            else       model_step(c + 2, DB, bus_b.raw_in[c]);
        end
        check_all();
    endtask

    initial begin
        int rc;
        int fc;
        int hc;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.raw_in = '0;
        bus_b.raw_in = '0;
        repeat (3) cycle();
        chk("reset_clean", bus_a.clean_out, 0);
        chk("reset_filt",  bus_a.filtering, 0);
        chk("reset_rise",  bus_a.rise_pulse, 0);
        chk("reset_fall",  bus_a.fall_pulse, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) cycle();

        // Clean rise on A[0]: j counts edges from the first one that samples the new level.
        bus_a.raw_in[0] = 1'b1;
        for (int j = 0; j < 9; j++) begin
            cycle();
            chk($sformatf("clean_rise_clean j=%0d", j), bus_a.clean_out[0], j >= DA + 2);
            chk($sformatf("clean_rise_filt j=%0d", j),  bus_a.filtering[0], (j >= 2) && (j <= DA + 1));
            chk($sformatf("clean_rise_pulse j=%0d", j), bus_a.rise_pulse[0], EDGE_EN && (j == DA + 2));
        end
        bus_a.raw_in[0] = 1'b0;
        repeat (DA + 4) cycle();
        chk("clean_fall_done", bus_a.clean_out[0], 0);

        // 4-cycle pulse is rejected, 5-cycle pulse is accepted then released.
        for (int len = DA; len <= DA + 1; len++) begin
            rc = 0; fc = 0; hc = 0;
            bus_a.raw_in[0] = 1'b1;
            for (int j = 0; j < len + DA + 6; j++) begin
                if (j == len) bus_a.raw_in[0] = 1'b0;
                cycle();
                rc += int'(bus_a.rise_pulse[0]);
                fc += int'(bus_a.fall_pulse[0]);
                hc += int'(bus_a.clean_out[0]);
            end
            chk($sformatf("glitch%0d_high_cycles", len), hc, (len == DA + 1) ? len : 0);
            chk($sformatf("glitch%0d_rise_cnt", len), rc, (len == DA + 1 && EDGE_EN) ? 1 : 0);
            chk($sformatf("glitch%0d_fall_cnt", len), fc, (len == DA + 1 && EDGE_EN) ? 1 : 0);
            chk($sformatf("glitch%0d_filt_end", len), bus_a.filtering[0], 0);
        end

        // Reset in the middle of filtering A[1].
        bus_a.raw_in[1] = 1'b1;
        repeat (3) cycle();
        chk("midrst_filt_before", bus_a.filtering[1], 1);
        #1 rst_a = 1'b1;
        #1;
        chk("midrst_clean", bus_a.clean_out, 0);
        chk("midrst_filt",  bus_a.filtering, 0);
        chk("midrst_rise",  bus_a.rise_pulse, 0);
        chk("midrst_fall",  bus_a.fall_pulse, 0);
        repeat (2) cycle();
        rst_a = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            cycle();
            chk($sformatf("midrst_relatch j=%0d", j), bus_a.clean_out[1], j >= 7);
        end
        bus_a.raw_in[1] = 1'b0;
        repeat (DA + 4) cycle();

        // Both channels rise together; channel 1 drops after 2 cycles.
        bus_a.raw_in = 2'b11;
        for (int j = 0; j < 10; j++) begin
            if (j == 2) bus_a.raw_in[1] = 1'b0;
            cycle();
            chk($sformatf("indep_c0 j=%0d", j), bus_a.clean_out[0], j >= DA + 2);
            chk($sformatf("indep_c1 j=%0d", j), bus_a.clean_out[1], 0);
        end
        bus_a.raw_in = '0;
        repeat (DA + 4) cycle();

        // Minimum debounce on B[0]: 1-cycle pulse rejected, 2-cycle pulse accepted.
        bus_b.raw_in[0] = 1'b1;
        for (int j = 0; j < 6; j++) begin
            if (j == 1) bus_b.raw_in[0] = 1'b0;
            cycle();
            chk($sformatf("min1_reject j=%0d", j), bus_b.clean_out[0], 0);
        end
        bus_b.raw_in[0] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (j == 2) bus_b.raw_in[0] = 1'b0;
            cycle();
            chk($sformatf("min2_accept j=%0d", j), bus_b.clean_out[0], (j == 3) || (j == 4));
            chk($sformatf("min2_rise j=%0d", j), bus_b.rise_pulse[0], EDGE_EN && (j == 3));
            chk($sformatf("min2_fall j=%0d", j), bus_b.fall_pulse[0], EDGE_EN && (j == 5));
        end

        // Random toggling on both DUTs, with one asynchronous reset burst on A.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(4) == 0) bus_a.raw_in = bus_a.raw_in ^ W'(1 << $urandom_range(W - 1));
            if ($urandom_range(3) == 0) bus_b.raw_in = bus_b.raw_in ^ W'(1 << $urandom_range(W - 1));
            if (i == 750) rst_a = 1'b1;
            if (i == 753) rst_a = 1'b0;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
